commit_monitor: RTL
===================

Name: commit_monitor

Overview:
- Parametrised successor to the single-issue commit/difftest glue between the `riscv` pipeline and the DiffTest ports.
- Accepts up to NCH commit records per cycle and re-aligns register-writeback info that leads commit by WB_LEAD cycles.
- Compacts valid records to the lowest output lanes in program order, maintains cycle/instruction counters, and latches trap events.
- Also generates the core's stretched post-reset pulse, replacing the ad-hoc one-shot reset logic.

Parameters:
- NCH, 2, commit lanes (1..4).
- WB_LEAD, 1, cycles by which writeback fields precede their commit valid (0..4).
- RST_CYCLES, 1, cycles core_rst stays high after reset deasserts (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- core_rst  out  1  reset to the pipeline.
- in_valid  in  NCH  per-lane commit valid; lane 0 is oldest.
- in_pc  in  NCH*64  per-lane committed pc.
- in_inst  in  NCH*32  per-lane instruction word.
- in_skip  in  NCH  per-lane difftest skip.
- in_wen  in  NCH  per-lane writeback enable, WB_LEAD cycles early.
- in_wdest  in  NCH*5  per-lane destination register.
- in_wdata  in  NCH*64  per-lane writeback data.
- in_trap_valid  in  1  halt/trap event.
- in_trap_code  in  3  trap code.
- in_trap_pc  in  64  pc of the trapping instruction.
- out_valid  out  NCH  compacted lane valids.
- out_pc  out  NCH*64  compacted pc.
- out_inst  out  NCH*32  compacted instruction.
- out_skip  out  NCH  compacted skip.
- out_wen  out  NCH  compacted writeback enable.
- out_wdest  out  NCH*8  compacted destination, zero-extended.
- out_wdata  out  NCH*64  compacted writeback data.
- trap_valid  out  1  one-cycle trap pulse.
- trap_code  out  3  latched trap code.
- trap_pc  out  64  latched trap pc.
- cycle_cnt  out  64  cycles since core_rst fell.
- instr_cnt  out  64  committed instructions.

Behaviour:
- Clocking and reset: all state on posedge clk. Reset is synchronous, active-high, and overrides everything.
- Reset values: core_rst=1 and all other outputs=0. The wb delay lines, the halted flag and the reset counter also clear.
- Reset sequencer: 4-bit counter rst_cnt loads RST_CYCLES on reset.
  - While rst_cnt!=0: core_rst=1 and rst_cnt decrements.
  - Once rst_cnt==0: core_rst=0 permanently until the next reset.
  - Result: core_rst is high for exactly RST_CYCLES cycles after the first cycle with reset low.
  - Reset asserted mid-sequence reloads the counter.
- While core_rst=1: in_valid, in_wen and in_trap_valid are ignored, and all delay-line entries are written as 0.
- WB alignment: per-lane shift register of depth WB_LEAD holding {wen, wdest, wdata}.
  - The commit in cycle t pairs with wb fields sampled in cycle t-WB_LEAD.
  - WB_LEAD=0 pairs with the same cycle, with no storage.
- Lane masking: wen is forced 0 where wdest==0. wen/wdest/wdata are forced 0 on lanes whose valid=0.
- Output latency: all out_* fields are registered, 1 cycle after in_valid.
- Compaction: let k = popcount(in_valid).
  - out lanes 0..k-1 carry the valid input lanes in ascending input index.
  - out lanes k..NCH-1 have valid=0 and all fields 0.
  - Example, NCH=2 with in_valid=2'b10: input lane 1 goes to out lane 0.
- instr_cnt: += popcount(out_valid) each cycle, including skipped instructions.
- cycle_cnt: += 1 each cycle where core_rst=0 and halted=0.
- Counters wrap modulo 2^64 silently.
- Trap handling:
  - On in_trap_valid with halted=0: trap_valid=1 for the next cycle only, trap_code/trap_pc latch, and halted sets.
  - While halted: in_valid is masked (out_valid=0), both counters freeze, further traps are ignored, and the trap outputs hold their values (trap_valid=0).
  - A commit in the same cycle as the trap is still emitted and counted; the trap applies from the following cycle.
  - Only reset clears halted.

Optional Feature:
- Macro: COMMIT_TRACE_EN.
- Defined: for each out lane with out_valid=1 at posedge, $display prints "commit[lane] pc inst wen wdest wdata", plus one "TRAP code pc" line on trap_valid. The port list and timing are identical to the undefined build.
- Undefined: no display code is compiled; the block is fully synthesizable.

Decomposition:
- Shared package commit_pkg holds:
  - typedef commit_rec_t {valid, pc, inst, skip, wen, wdest[7:0], wdata};
  - typedef wb_rec_t {wen, wdest[4:0], wdata};
  - constant TRAP_CODE_W=3.
- The shift register is implemented as sub-module wb_delay_line (params DEPTH, WIDTH; ports clk, reset, clr, d, q), instantiated once per lane. DEPTH=0 degenerates to a wire.

Test Plan:
- Reset sequencer: RST_CYCLES=3, reset high 2 cycles then low -> core_rst high exactly 3 further cycles; cycle_cnt=0 at the fall, then increments by 1 per cycle.
- WB alignment: WB_LEAD=1, in_wen=1/wdest=5/wdata=0xAB at cycle t, in_valid[0]=1/pc=0x80000000 at t+1 -> out at t+2: valid[0]=1, wen=1, wdest=8'h05, wdata=0xAB.
- x0 masking: wdest=0 with wen=1 -> out_wen=0 and out_wdata=0.
- Compaction: NCH=2, in_valid=2'b10 with pc1=0x80000004 -> out_valid=2'b01, out_pc[0]=0x80000004; in_valid=2'b11 -> instr_cnt increases by 2.
- Trap: trap code=0/pc=0x80000010 in the same cycle as a valid commit -> that commit is counted; trap_valid pulses 1 cycle; afterwards in_valid=2'b11 gives out_valid=0 and cycle_cnt/instr_cnt stay frozen.
- Mid-operation reset: assert reset while halted with counters at 100 -> next cycle all outputs 0, core_rst=1, halted cleared, delay lines empty (no stale wen after the new reset sequence).

Source files
------------

// File: rtl/commit_pkg.sv
// commit_pkg: record types and constants shared by commit_monitor and its delay lines
package commit_pkg;
  localparam int TRAP_CODE_W = 3;
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        skip;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
  } commit_rec_t;
  typedef struct packed {
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
  } wb_rec_t;
endpackage

// File: rtl/wb_delay_line.sv
// wb_delay_line: DEPTH-stage shift register for early writeback fields; DEPTH=0 is a plain wire
module wb_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge clk) begin
      if (reset || clr) sr <= '{default: '0};
      else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/commit_monitor.sv
// commit_monitor: multi-lane commit compaction, wb re-alignment, counters, trap latch and core reset stretcher
// Optional COMMIT_TRACE_EN compiles a per-commit/trap $display trace.
module commit_monitor
  import commit_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int WB_LEAD    = 1,
  parameter int RST_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   core_rst,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*64-1:0]      in_pc,
  input  logic [NCH*32-1:0]      in_inst,
  input  logic [NCH-1:0]         in_skip,
  input  logic [NCH-1:0]         in_wen,
  input  logic [NCH*5-1:0]       in_wdest,
  input  logic [NCH*64-1:0]      in_wdata,
  input  logic                   in_trap_valid,
  input  logic [TRAP_CODE_W-1:0] in_trap_code,
  input  logic [63:0]            in_trap_pc,
  output logic [NCH-1:0]         out_valid,
  output logic [NCH*64-1:0]      out_pc,
  output logic [NCH*32-1:0]      out_inst,
  output logic [NCH-1:0]         out_skip,
  output logic [NCH-1:0]         out_wen,
  output logic [NCH*8-1:0]       out_wdest,
  output logic [NCH*64-1:0]      out_wdata,
  output logic                   trap_valid,
  output logic [TRAP_CODE_W-1:0] trap_code,
  output logic [63:0]            trap_pc,
  output logic [63:0]            cycle_cnt,
  output logic [63:0]            instr_cnt
);
  logic [3:0]  rst_cnt;
  logic        halted;
  logic        live;
  logic        trap_hit;
  logic [2:0]  n;
  wb_rec_t     wb_d [NCH];
  wb_rec_t     wb_q [NCH];
  commit_rec_t rec [NCH];
  commit_rec_t cmp [NCH];
  commit_rec_t out_rec [NCH];
  assign core_rst = |rst_cnt;
  assign live     = ~core_rst & ~halted;
  assign trap_hit = in_trap_valid & live;
  for (genvar l = 0; l < NCH; l++) begin : g_lane
    assign wb_d[l] = '{wen: in_wen[l], wdest: in_wdest[l*5 +: 5], wdata: in_wdata[l*64 +: 64]};
    wb_delay_line #(.DEPTH(WB_LEAD), .WIDTH($bits(wb_rec_t))) u_wb (
      .clk(clk), .reset(reset), .clr(core_rst), .d(wb_d[l]), .q(wb_q[l])
    );
    // x0 writes are dropped entirely, data included
    assign rec[l] = (in_valid[l] && live) ? commit_rec_t'{
      valid: 1'b1,
      pc:    in_pc[l*64 +: 64],
      inst:  in_inst[l*32 +: 32],
      skip:  in_skip[l],
      wen:   wb_q[l].wen && |wb_q[l].wdest,
      wdest: {3'b000, wb_q[l].wdest},
      wdata: |wb_q[l].wdest ? wb_q[l].wdata : 64'd0
    } : '0;
    assign out_valid[l]           = out_rec[l].valid;
    assign out_pc[l*64 +: 64]     = out_rec[l].pc;
    assign out_inst[l*32 +: 32]   = out_rec[l].inst;
    assign out_skip[l]            = out_rec[l].skip;
    assign out_wen[l]             = out_rec[l].wen;
    assign out_wdest[l*8 +: 8]    = out_rec[l].wdest;
    assign out_wdata[l*64 +: 64]  = out_rec[l].wdata;
  end
  always_comb begin
    cmp = '{default: '0};
    n = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < NCH; j++) if (rec[i].valid && n == 3'(j)) cmp[j] = rec[i];
      n = n + 3'(rec[i].valid);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt    <= 4'(RST_CYCLES);
      halted     <= 1'b0;
      out_rec    <= '{default: '0};
      trap_valid <= 1'b0;
      trap_code  <= '0;
      trap_pc    <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
    end else begin
      rst_cnt    <= core_rst ? rst_cnt - 4'd1 : rst_cnt;
      out_rec    <= cmp;
      instr_cnt  <= instr_cnt + 64'(n);
      cycle_cnt  <= cycle_cnt + 64'(live);
      trap_valid <= trap_hit;
      if (trap_hit) begin
        trap_code <= in_trap_code;
        trap_pc   <= in_trap_pc;
        halted    <= 1'b1;
      end
    end
  end
`ifdef COMMIT_TRACE_EN
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (out_rec[i].valid)
        $display("commit[%0d] %h %h %0d %0d %h", i, out_rec[i].pc, out_rec[i].inst,
                 out_rec[i].wen, out_rec[i].wdest, out_rec[i].wdata);
    if (trap_valid) $display("TRAP %0d %h", trap_code, trap_pc);
  end
`endif
endmodule
